// File: rtl/decode_stage_p_pkg.sv
// rtl/decode_stage_p_pkg.sv - RV32I opcodes, branch func_3 codes and immediate-format decode helpers
package decode_stage_p_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // Only R, S and B formats read rs2; others reuse those bits as immediate.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

    // Returns the 32-bit sign-extended immediate; inst[6:0] is not needed here.
    function automatic logic [31:0] imm_of(input logic [31:7] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file_p.sv
// rtl/register_file_p.sv - 2R1W register file, x0 hardwired 0; STAGE_2_BYPASS_EN forwards same-cycle writes
module register_file_p
    import decode_stage_p_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr_1,
    input  logic [REG_AW-1:0] raddr_2,
    output logic [XLEN-1:0]   rdata_1,
    output logic [XLEN-1:0]   rdata_2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_1 = (raddr_1 == '0) ? '0 : regs[raddr_1];
        rdata_2 = (raddr_2 == '0) ? '0 : regs[raddr_2];
`ifdef STAGE_2_BYPASS_EN
        if (wr_en && (waddr == raddr_1)) begin
            rdata_1 = wdata;
        end
        if (wr_en && (waddr == raddr_2)) begin
            rdata_2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - registered RV32I decode stage with branch resolve and load-use stall (option STAGE_2_BYPASS_EN)
module decode_stage_p
    import decode_stage_p_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_inst,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_reg_op,
    input  logic [REG_AW-1:0] i_w_rd_num,
    input  logic [XLEN-1:0]   i_w_rd,
    input  logic              i_ex_load,
    input  logic [REG_AW-1:0] i_ex_rd_num,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_rs_1,
    output logic [XLEN-1:0]   o_rs_2,
    output logic [XLEN-1:0]   o_imm,
    output logic [REG_AW-1:0] o_rd_num,
    output logic [6:0]        o_opcode,
    output logic [2:0]        o_func_3,
    output logic [6:0]        o_func_7,
    output logic              o_b_taken,
    output logic [XLEN-1:0]   o_b_pc
);

    logic [6:0]        opcode;
    logic [2:0]        func_3;
    logic [6:0]        func_7;
    logic [REG_AW-1:0] rd_num;
    logic [REG_AW-1:0] rs1_num;
    logic [REG_AW-1:0] rs2_num;
    imm_fmt_e          imm_fmt;
    logic [31:0]       imm_32;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              hazard;
    logic              accept;
    logic              drop;
    logic              kill;
    logic              br_take;
    logic [XLEN-1:0]   br_target;

    assign opcode  = i_inst[6:0];
    assign rd_num  = REG_AW'(i_inst[11:7]);
    assign func_3  = i_inst[14:12];
    assign rs1_num = REG_AW'(i_inst[19:15]);
    assign rs2_num = REG_AW'(i_inst[24:20]);
    assign func_7  = i_inst[31:25];
    assign imm_fmt = imm_fmt_of(opcode);
    assign imm_32  = imm_of(i_inst[31:7], imm_fmt);
    assign imm     = XLEN'($signed(imm_32));

    register_file_p #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_register_file (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .we      (i_reg_op),
        .waddr   (i_w_rd_num),
        .wdata   (i_w_rd),
        .raddr_1 (rs1_num),
        .raddr_2 (rs2_num),
        .rdata_1 (rs1_val),
        .rdata_2 (rs2_val)
    );

    // rs1 is compared for every opcode, so formats without rs1 may stall conservatively.
    assign hazard = i_valid && i_ex_load && (i_ex_rd_num != '0) &&
                    ((i_ex_rd_num == rs1_num) ||
                     (uses_rs2(opcode) && (i_ex_rd_num == rs2_num)));

    assign o_ready = !hazard && (!o_valid || i_ready);
    assign accept  = i_valid && o_ready && !kill;
    assign drop    = i_valid && o_ready && kill;

    always_comb begin
        br_take   = 1'b0;
        br_target = i_pc + imm;
        case (opcode)
            OP_JAL: br_take = 1'b1;
            OP_JALR: begin
                br_take   = 1'b1;
                br_target = (rs1_val + imm) & ~XLEN'(1);
            end
            OP_BRANCH: begin
                case (func_3)
                    F3_BEQ:  br_take = (rs1_val == rs2_val);
                    F3_BNE:  br_take = (rs1_val != rs2_val);
                    F3_BLT:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
                    F3_BGE:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
                    F3_BLTU: br_take = (rs1_val <  rs2_val);
                    F3_BGEU: br_take = (rs1_val >= rs2_val);
                    default: br_take = 1'b0;
                endcase
            end
            default: br_take = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_valid   <= 1'b0;
            o_pc      <= '0;
            o_rs_1    <= '0;
            o_rs_2    <= '0;
            o_imm     <= '0;
            o_rd_num  <= '0;
            o_opcode  <= '0;
            o_func_3  <= '0;
            o_func_7  <= '0;
            o_b_taken <= 1'b0;
            o_b_pc    <= '0;
            kill      <= 1'b0;
        end else if (i_flush) begin
            o_valid   <= 1'b0;
            o_b_taken <= 1'b0;
            kill      <= 1'b0;
        end else if (accept) begin
            o_valid   <= 1'b1;
            o_pc      <= i_pc;
            o_rs_1    <= rs1_val;
            o_rs_2    <= rs2_val;
            o_imm     <= imm;
            o_rd_num  <= rd_num;
            o_opcode  <= opcode;
            o_func_3  <= func_3;
            o_func_7  <= func_7;
            o_b_taken <= br_take;
            if (br_take) begin
                o_b_pc <= br_target;
                kill   <= 1'b1;
            end
        end else begin
            // Covers bubble, drained output and dropped wrong-path slot alike.
            o_b_taken <= 1'b0;
            if (i_ready) begin
                o_valid <= 1'b0;
            end
            if (drop) begin
                kill <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - directed and randomized checks of decode_stage_p against a behavioural model
module tb_decode_stage_p;

    localparam logic [6:0] L_LUI = 7'h37, L_AUIPC = 7'h17, L_JAL = 7'h6F, L_JALR = 7'h67;
    localparam logic [6:0] L_BR = 7'h63, L_LOAD = 7'h03, L_STORE = 7'h23, L_IMM = 7'h13, L_REG = 7'h33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, reg_op, ex_load, flush, rdy_in;
    logic [31:0] inst, pc, w_val;
    logic [4:0]  w_num, ex_rd;

    logic        o_ready, o_valid, o_b_taken;
    logic [31:0] o_pc, o_rs_1, o_rs_2, o_imm, o_b_pc;
    logic [4:0]  o_rd_num;
    logic [6:0]  o_opcode, o_func_7;
    logic [2:0]  o_func_3;

    int n_checks = 0;
    int n_errors = 0;
    logic last_ready;

    logic [31:0] m_regs [32];
    logic        m_valid, m_bt, m_kill;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_bpc;
    logic [4:0]  m_rd;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;

    always #5 clk = ~clk;

    decode_stage_p dut (
        .i_clk(clk), .i_rst(rst_n), .i_valid(iv), .o_ready(o_ready),
        .i_inst(inst), .i_pc(pc), .i_reg_op(reg_op), .i_w_rd_num(w_num), .i_w_rd(w_val),
        .i_ex_load(ex_load), .i_ex_rd_num(ex_rd), .i_flush(flush), .i_ready(rdy_in),
        .o_valid(o_valid), .o_pc(o_pc), .o_rs_1(o_rs_1), .o_rs_2(o_rs_2), .o_imm(o_imm),
        .o_rd_num(o_rd_num), .o_opcode(o_opcode), .o_func_3(o_func_3), .o_func_7(o_func_7),
        .o_b_taken(o_b_taken), .o_b_pc(o_b_pc)
    );

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_imm_of(input logic [31:0] ins);
        int v;
        int sgn;
        sgn = ins[31] ? 1 : 0;
        case (ins[6:0])
            L_IMM, L_LOAD, L_JALR: v = int'($signed(ins)) >>> 20;
            L_STORE: v = ((int'($signed(ins)) >>> 25) * 32) + int'(ins[11:7]);
            L_BR:    v = -4096 * sgn + 2048 * int'(ins[7]) + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]);
            L_LUI, L_AUIPC: v = int'(ins & 32'hFFFFF000);
            L_JAL:   v = -(1 << 20) * sgn + (int'(ins[19:12]) << 12) + 2048 * int'(ins[20]) + 2 * int'(ins[30:21]);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
`ifdef STAGE_2_BYPASS_EN
        if (reg_op && w_num == r) return w_val;
`endif
        return m_regs[r];
    endfunction

    function automatic logic m_hazard();
        logic [6:0] op = inst[6:0];
        logic rs2_used = (op == L_REG) || (op == L_STORE) || (op == L_BR);
        return iv && ex_load && ex_rd != 0 &&
               (ex_rd == inst[19:15] || (rs2_used && ex_rd == inst[24:20]));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 0; m_bt = 0; m_kill = 0;
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_bpc = 0;
        m_rd = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
    endtask

    task automatic m_update();
        logic rdy, taken;
        logic [31:0] a, b, tgt;
        rdy = !m_hazard() && (!m_valid || rdy_in);
        a = m_read(inst[19:15]);
        b = m_read(inst[24:20]);
        taken = 0;
        tgt = pc + m_imm_of(inst);
        case (inst[6:0])
            L_JAL: taken = 1;
            L_JALR: begin taken = 1; tgt = (a + m_imm_of(inst)) & 32'hFFFFFFFE; end
            L_BR: case (inst[14:12])
                3'd0: taken = (a == b);
                3'd1: taken = (a != b);
                3'd4: taken = ($signed(a) < $signed(b));
                3'd5: taken = ($signed(a) >= $signed(b));
                3'd6: taken = (a < b);
                3'd7: taken = (a >= b);
                default: taken = 0;
            endcase
            default: taken = 0;
        endcase
        if (flush) begin
            m_valid = 0; m_kill = 0; m_bt = 0;
        end else if (iv && rdy && !m_kill) begin
            m_valid = 1; m_pc = pc; m_rs1 = a; m_rs2 = b; m_imm = m_imm_of(inst);
            m_rd = inst[11:7]; m_op = inst[6:0]; m_f3 = inst[14:12]; m_f7 = inst[31:25];
            m_bt = taken;
            if (taken) begin m_bpc = tgt; m_kill = 1; end
        end else begin
            m_bt = 0;
            if (rdy_in) m_valid = 0;
            if (iv && rdy && m_kill) m_kill = 0;
        end
        if (reg_op && w_num != 0) m_regs[w_num] = w_val;
    endtask

    task automatic tick();
        #1;
        last_ready = o_ready;
        check_eq("o_ready", o_ready, !m_hazard() && (!m_valid || rdy_in));
        @(posedge clk);
        m_update();
        #1;
        check_eq("o_valid", o_valid, m_valid);
        check_eq("o_b_taken", o_b_taken, m_bt);
        check_eq("o_b_pc", o_b_pc, m_bpc);
        if (m_valid)
            check_eq("fields", {o_pc, o_rs_1, o_rs_2, o_imm, o_rd_num, o_opcode, o_func_3, o_func_7},
                     {m_pc, m_rs1, m_rs2, m_imm, m_rd, m_op, m_f3, m_f7});
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic r);
        iv = v; inst = ins; pc = p; rdy_in = r;
    endtask

    task automatic wb(input logic [4:0] n, input logic [31:0] val);
        iv = 0; rdy_in = 1; reg_op = 1; w_num = n; w_val = val;
        tick();
        reg_op = 0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9] = '{L_LUI, L_AUIPC, L_JAL, L_JALR, L_BR, L_LOAD, L_STORE, L_IMM, L_REG};
        logic [31:0] r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 8)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        rst_n = 0; iv = 0; inst = 0; pc = 0; reg_op = 0; w_num = 0; w_val = 0;
        ex_load = 0; ex_rd = 0; flush = 0; rdy_in = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_b_taken", o_b_taken, 0);
        check_eq("rst_outs", {o_pc, o_rs_1, o_rs_2, o_imm, o_b_pc, o_rd_num}, 0);
        rst_n = 1;

        set_in(1, 32'h00500093, 32'h0, 1); tick();
        check_eq("t1_valid", o_valid, 1);
        check_eq("t1_imm", o_imm, 5);
        check_eq("t1_rd", o_rd_num, 1);
        check_eq("t1_rs1", o_rs_1, 0);

        wb(2, 32'h9);
        ex_load = 1; ex_rd = 3;
        set_in(1, 32'h00218233, 32'h10, 1); tick();
        check_eq("t2_stall_ready", last_ready, 0);
        check_eq("t2_bubble", o_valid, 0);
        ex_load = 0; tick();
        check_eq("t2_accept", o_valid, 1);
        check_eq("t2_rs2", o_rs_2, 9);

        wb(1, 32'h7); wb(2, 32'h7);
        set_in(1, 32'h00208863, 32'h100, 1); tick();
        check_eq("t3_taken", o_b_taken, 1);
        check_eq("t3_target", o_b_pc, 32'h110);
        set_in(1, 32'h00500093, 32'h104, 1); tick();
        check_eq("t3_pulse", o_b_taken, 0);
        check_eq("t3_dropped", o_valid, 0);
        tick();
        check_eq("t3_resume_pc", o_pc, 32'h104);

        wb(5, 32'h204);
        set_in(1, 32'hFFD28067, 32'h180, 1); tick();
        check_eq("t4_jalr_target", o_b_pc, 32'h200);
        set_in(1, 32'h00000013, 32'h184, 1); tick();
        wb(1, 32'hFFFFFFFF); wb(2, 32'h1);
        set_in(1, 32'h0020E463, 32'h190, 1); tick();
        check_eq("t4_bltu_not_taken", o_b_taken, 0);
        check_eq("t4_bltu_valid", o_valid, 1);

        wb(6, 32'h11);
        reg_op = 1; w_num = 6; w_val = 32'hAB;
        set_in(1, 32'h000303B3, 32'h1A0, 1); tick();
        reg_op = 0;
`ifdef STAGE_2_BYPASS_EN
        check_eq("t5_bypass", o_rs_1, 32'hAB);
`else
        check_eq("t5_no_bypass", o_rs_1, 32'h11);
`endif
        reg_op = 1; w_num = 0; w_val = 32'h55;
        set_in(1, 32'h00000433, 32'h1A4, 1); tick();
        reg_op = 0;
        check_eq("t5_x0_same", o_rs_1, 0);
        tick();
        check_eq("t5_x0_after", o_rs_1, 0);

        set_in(0, 32'h0, 32'h0, 1); tick();
        set_in(1, 32'h00500093, 32'h300, 0); tick();
        check_eq("t6_valid", o_valid, 1);
        set_in(1, 32'h00218233, 32'h400, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_hold_pc", o_pc, 32'h300);
            check_eq("t6_hold_imm", o_imm, 5);
            check_eq("t6_hold_ready", last_ready, 0);
        end
        rst_n = 0;
        #1;
        check_eq("t6_async_valid", o_valid, 0);
        check_eq("t6_async_outs", {o_pc, o_imm, o_b_pc, o_rd_num, o_opcode}, 0);
        m_reset();
        set_in(0, 32'h0, 32'h0, 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        set_in(1, 32'h0080006F, 32'h500, 1); tick();
        check_eq("t6_jal_target", o_b_pc, 32'h508);
        set_in(0, 32'h0, 32'h0, 1); flush = 1; tick();
        flush = 0;
        check_eq("t6_flush_pulse", o_b_taken, 0);
        set_in(1, 32'h00500093, 32'h600, 1); tick();
        check_eq("t6_kill_cleared", o_valid, 1);
        check_eq("t6_kill_pc", o_pc, 32'h600);

        for (int c = 0; c < 400; c++) begin
            iv      = ($urandom_range(0, 3) != 0);
            inst    = rand_inst();
            pc      = $urandom & 32'h0000FFFC;
            rdy_in  = ($urandom_range(0, 3) != 0);
            ex_load = ($urandom_range(0, 2) == 0);
            ex_rd   = 5'($urandom_range(0, 7));
            reg_op  = 1'($urandom_range(0, 1));
            w_num   = 5'($urandom_range(0, 7));
            w_val   = $urandom;
            flush   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
